// File: rtl/multi_acc_pipe.sv
// Dot-product accumulator behind the pipelined multiplier: sums every len valid
// products and queues each result in a 2-entry valid/ready output buffer.
module multi_acc_pipe #(
  parameter int size = 8,
  parameter int len  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mul_en_out,
  input  logic [2*size-1:0]   mul_out,
  input  logic                acc_clr,
  input  logic                acc_ready,
  output logic                acc_valid,
  output logic [2*size+3:0]   acc_out,
  output logic                acc_busy,
  output logic                drop_err
);

  localparam int W     = 2*size + 4;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(len - 1);

  logic [W-1:0]     acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [W-1:0]     mem_reg [2];
  logic             wr_ptr_reg, rd_ptr_reg;
  logic [1:0]       occ_reg, occ_next;
  logic [W-1:0]     head_reg, head_next;
  logic             drop_reg, drop_next;

  logic [W-1:0]     sum;
  logic             take, frame_end, pop, push, lost;

  always_comb begin
    sum       = acc_reg + W'(mul_out);
    take      = mul_en_out & ~acc_clr;
    frame_end = take & (cnt_reg == LAST);
    pop       = (occ_reg != 2'd0) & acc_ready;
    // A full queue still accepts a result when the head leaves in the same cycle.
    push      = frame_end & ((occ_reg != 2'd2) | pop);
    lost      = frame_end & ~push;

    acc_next = acc_reg;
    cnt_next = cnt_reg;
    if (acc_clr || frame_end) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (take) begin
      acc_next = sum;
      cnt_next = cnt_reg + CNT_W'(1);
    end

    occ_next = occ_reg + {1'b0, push} - {1'b0, pop};

    // Head register keeps acc_out stable, including after the queue drains.
    head_next = head_reg;
    if (pop && occ_reg == 2'd2)
      head_next = mem_reg[~rd_ptr_reg];
    else if (push && (occ_reg == 2'd0 || pop))
      head_next = sum;

    drop_next = acc_clr ? 1'b0 : (drop_reg | lost);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      cnt_reg    <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
      head_reg   <= '0;
      drop_reg   <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_next;
      occ_reg  <= occ_next;
      head_reg <= head_next;
      drop_reg <= drop_next;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_reg[wr_ptr_reg] <= sum;
  end

  assign acc_valid = (occ_reg != 2'd0);
  assign acc_out   = head_reg;
  assign acc_busy  = (cnt_reg != '0);
  assign drop_err  = drop_reg;

endmodule

// File: tb/tb_multi_acc_pipe.sv
// Bench for multi_acc_pipe: three instances (len 4, 16, 1) share one input
// stream and are compared every cycle against a queue-based reference model.
module tb_multi_acc_pipe;

  logic        clk = 1'b0;
  logic        rst, en, clr, ready;
  logic [15:0] mul;
  logic        valid_w [3];
  logic [19:0] out_w   [3];
  logic        busy_w  [3];
  logic        drop_w  [3];

  int errors = 0;
  int checks = 0;

  int unsigned m_acc  [3];
  int unsigned m_cnt  [3];
  int unsigned mq     [3][$];
  bit          m_drop [3];
  int unsigned m_head [3];

  always #5 clk = ~clk;

  multi_acc_pipe #(.size(8), .len(4)) u_len4 (
    .clk(clk), .rst(rst), .mul_en_out(en), .mul_out(mul), .acc_clr(clr),
    .acc_ready(ready), .acc_valid(valid_w[0]), .acc_out(out_w[0]),
    .acc_busy(busy_w[0]), .drop_err(drop_w[0]));

  multi_acc_pipe #(.size(8), .len(16)) u_len16 (
    .clk(clk), .rst(rst), .mul_en_out(en), .mul_out(mul), .acc_clr(clr),
    .acc_ready(ready), .acc_valid(valid_w[1]), .acc_out(out_w[1]),
    .acc_busy(busy_w[1]), .drop_err(drop_w[1]));

  multi_acc_pipe #(.size(8), .len(1)) u_len1 (
    .clk(clk), .rst(rst), .mul_en_out(en), .mul_out(mul), .acc_clr(clr),
    .acc_ready(ready), .acc_valid(valid_w[2]), .acc_out(out_w[2]),
    .acc_busy(busy_w[2]), .drop_err(drop_w[2]));

  function automatic int unsigned len_of(int k);
    return (k == 0) ? 4 : (k == 1) ? 16 : 1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: frames counted in whole products, results held in a queue of depth 2.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int unsigned lk;
      int unsigned res;
      bit          have;
      bit          popped;
      lk   = len_of(k);
      res  = 0;
      have = 0;
      if (rst) begin
        m_acc[k] = 0; m_cnt[k] = 0; mq[k].delete(); m_drop[k] = 0; m_head[k] = 0;
      end else begin
        popped = ready && (mq[k].size() != 0);
        if (clr) begin
          m_acc[k] = 0; m_cnt[k] = 0; m_drop[k] = 0;
        end else if (en) begin
          m_acc[k] += mul;
          m_cnt[k]++;
          if (m_cnt[k] == lk) begin
            res = m_acc[k]; have = 1; m_acc[k] = 0; m_cnt[k] = 0;
          end
        end
        if (popped) void'(mq[k].pop_front());
        if (have) begin
          if (mq[k].size() < 2) mq[k].push_back(res);
          else m_drop[k] = 1;
        end
        if (mq[k].size() != 0) m_head[k] = mq[k][0];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("i%0d_valid", k), 32'(valid_w[k]), 32'(mq[k].size() != 0));
      check($sformatf("i%0d_out", k),   32'(out_w[k]),   m_head[k]);
      check($sformatf("i%0d_busy", k),  32'(busy_w[k]),  32'(m_cnt[k] != 0));
      check($sformatf("i%0d_drop", k),  32'(drop_w[k]),  32'(m_drop[k]));
    end
  endtask

  initial begin
    int unsigned prods [4];
    int          thr;
    prods = '{15, 10, 20, 100};

    // Reset
    rst = 1; en = 0; clr = 0; ready = 0; mul = 0;
    step(); step();
    check("rst_valid", 32'(valid_w[0]), 0);
    check("rst_out",   32'(out_w[0]),   0);
    check("rst_busy",  32'(busy_w[0]),  0);
    check("rst_drop",  32'(drop_w[0]),  0);
    rst = 0;

    // Basic frame
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      en = 1; mul = 16'(prods[i]); step();
      check("basic_busy", 32'(busy_w[0]), 32'(i < 3));
    end
    check("basic_valid", 32'(valid_w[0]), 1);
    check("basic_out",   32'(out_w[0]),   145);
    $display("basic frame result %0d", out_w[0]);
    en = 0; step();
    check("basic_valid_1cyc", 32'(valid_w[0]), 0);
    check("basic_out_hold",   32'(out_w[0]),   145);

    // Gapped frame
    clr = 1; step(); clr = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin en = 0; step(); step(); end
      en = 1; mul = 16'(prods[i]); step();
    end
    check("gap_valid", 32'(valid_w[0]), 1);
    check("gap_out",   32'(out_w[0]),   145);
    $display("gapped frame result %0d", out_w[0]);

    // Max value, len 16
    en = 0; clr = 1; step(); clr = 0;
    for (int i = 0; i < 16; i++) begin
      en = 1; mul = 16'd65025; step();
    end
    check("max_valid", 32'(valid_w[1]), 1);
    check("max_out",   32'(out_w[1]),   1040400);
    $display("max frame result %0d", out_w[1]);
    en = 0; step();

    // Backpressure and drop, len 1
    ready = 0;
    for (int i = 1; i <= 3; i++) begin
      en = 1; mul = 16'(i); step();
    end
    check("bp_valid", 32'(valid_w[2]), 1);
    check("bp_out1",  32'(out_w[2]),   1);
    check("bp_drop",  32'(drop_w[2]),  1);
    en = 0; ready = 1; step();
    check("bp_out2",  32'(out_w[2]),   2);
    check("bp_valid2", 32'(valid_w[2]), 1);
    step();
    check("bp_empty", 32'(valid_w[2]), 0);
    check("bp_no3",   32'(out_w[2]),   2);
    $display("backpressure popped 1,2 drop_err=%0d", drop_w[2]);

    // Full-queue push with simultaneous pop
    clr = 1; ready = 0; step(); clr = 0;
    en = 1; mul = 7; step();
    mul = 8; step();
    check("fq_out7", 32'(out_w[2]), 7);
    mul = 9; ready = 1; step();
    check("fq_out8", 32'(out_w[2]), 8);
    check("fq_drop", 32'(drop_w[2]), 0);
    en = 0; step();
    check("fq_out9", 32'(out_w[2]), 9);
    check("fq_valid9", 32'(valid_w[2]), 1);
    step();
    check("fq_empty", 32'(valid_w[2]), 0);
    $display("full-queue push with pop sequence 7,8,9");

    // Abort
    clr = 1; step(); clr = 0; ready = 1;
    en = 1; mul = 5; step();
    mul = 6; step();
    check("abort_busy_pre", 32'(busy_w[0]), 1);
    clr = 1; mul = 7; step(); clr = 0;
    check("abort_busy", 32'(busy_w[0]), 0);
    check("abort_nopush", 32'(valid_w[0]), 0);
    for (int i = 0; i < 4; i++) begin mul = 1; step(); end
    check("abort_valid", 32'(valid_w[0]), 1);
    check("abort_out",   32'(out_w[0]),   4);
    $display("post-abort frame result %0d", out_w[0]);
    mul = 2; step(); mul = 3; step();
    check("rst_mid_busy_pre", 32'(busy_w[0]), 1);
    rst = 1; mul = 9; step(); rst = 0;
    check("rst_mid_valid", 32'(valid_w[0]), 0);
    check("rst_mid_out",   32'(out_w[0]),   0);
    check("rst_mid_busy",  32'(busy_w[0]),  0);
    check("rst_mid_drop",  32'(drop_w[0]),  0);
    check("rst_mid_out2",  32'(out_w[2]),   0);

    // Randomised traffic with varying backpressure
    thr = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) thr = int'($urandom_range(0, 4));
      rst   = ($urandom % 250) == 0;
      clr   = ($urandom % 40) == 0;
      en    = ($urandom % 10) < 7;
      mul   = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
      ready = int'($urandom % 4) < thr;
      step();
    end
    $display("random phase done, %0d cycles", 3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
